// File: rtl/phy_free_list_pkg.sv
// Shared constants and types for the physical-register free list.
//   PHY_REGS  : number of physical registers (6-bit tags)
//   ARCH_REGS : architectural registers, identity-mapped at reset (p0..p31)
//   FL_DEPTH  : free-list entries (PHY_REGS - ARCH_REGS)
//   PHY_TAG_W : physical tag width
package phy_free_list_pkg;

  localparam int unsigned PHY_REGS  = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned FL_DEPTH  = PHY_REGS - ARCH_REGS;
  localparam int unsigned PHY_TAG_W = 6;

  typedef logic [PHY_TAG_W-1:0] phy_tag_t;
  // 5-bit index plus wrap bit.
  typedef logic [5:0]           fl_ptr_t;

  // Number of set bits in a 2-bit request/valid vector.
  function automatic logic [1:0] popcnt2(logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/phy_free_list_ptr_adv.sv
// Pointer advance: ptr_o = ptr_i + inc_i (mod 64). Wrap bit falls out of the
// 6-bit arithmetic naturally.
//   ptr_i : current pointer (index + wrap bit)
//   inc_i : increment, 0..2
//   ptr_o : advanced pointer
module fl_ptr_adv
  import phy_free_list_pkg::*;
(
  input  logic [5:0] ptr_i,
  input  logic [1:0] inc_i,
  output logic [5:0] ptr_o
);

  assign ptr_o = ptr_i + {4'b0000, inc_i};

endmodule

// File: rtl/phy_free_list.sv
// Physical-register free list for a 2-wide rename stage.
// Circular FIFO of free tags: speculative head (hs) is consumed at rename,
// committed head (hc) tracks retired allocations, tail (t) receives old
// mappings released at commit. A flush rewinds hs to the committed head.
// Tag p0 is hard-mapped to $0 and is never written into the list.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : pipeline flush, discards uncommitted allocations
//   stall_i              : downstream stall, blocks allocation
//   alloc_req_i[1:0]     : bit0 = inst1 needs dst, bit1 = inst2 needs dst
//   alloc_phydst1_o/2_o  : allocated tags (0 when slot not requested)
//   stall_o              : not enough free tags for this cycle's requests
//   commit_cnt_i[1:0]    : committing instructions that allocated a dst (0..2)
//   free_en_i[1:0]       : per-slot release enable
//   free_phydst1_i/2_i   : old tags being released
//   free_count_o         : speculative free count (0..32)
//   fl_err_o             : sticky consistency error (only with PHY_FREE_CHK_EN)
//
// Optional feature macro: PHY_FREE_CHK_EN (adds fl_err_o and its checks).
module phy_free_list
  import phy_free_list_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       stall_i,
  input  logic [1:0] alloc_req_i,
  output logic [5:0] alloc_phydst1_o,
  output logic [5:0] alloc_phydst2_o,
  output logic       stall_o,
  input  logic [1:0] commit_cnt_i,
  input  logic [1:0] free_en_i,
  input  logic [5:0] free_phydst1_i,
  input  logic [5:0] free_phydst2_i,
`ifdef PHY_FREE_CHK_EN
  output logic       fl_err_o,
`endif
  output logic [5:0] free_count_o
);

  phy_tag_t entry_q [FL_DEPTH];

  fl_ptr_t hs_q, hs_d, hs_adv;
  fl_ptr_t hc_q, hc_d;
  fl_ptr_t t_q,  t_d;

  fl_ptr_t    free_cnt;
  logic [1:0] alloc_n;
  logic       alloc_go;
  logic [1:0] hs_inc;

  logic       fv1, fv2;
  logic [1:0] free_n;
  logic [4:0] widx1, widx2;
  logic [4:0] ridx1, ridx2;

  // ---------------------------------------------------------------------------
  // Occupancy and allocation
  // ---------------------------------------------------------------------------
  assign free_cnt     = t_q - hs_q;
  assign free_count_o = free_cnt;

  assign alloc_n  = popcnt2(alloc_req_i);
  // Uses the pre-edge count only; frees arriving this cycle do not help.
  assign stall_o  = free_cnt < {4'b0000, alloc_n};
  assign alloc_go = !stall_i && !stall_o && !flush_i;
  assign hs_inc   = alloc_go ? alloc_n : 2'd0;

  // Slot 2 takes the next entry only when slot 1 also consumes one.
  assign ridx1 = hs_q[4:0];
  assign ridx2 = hs_q[4:0] + {4'b0000, alloc_req_i[0]};

  // Candidate tags are presented even when stalled.
  assign alloc_phydst1_o = alloc_req_i[0] ? entry_q[ridx1] : 6'd0;
  assign alloc_phydst2_o = alloc_req_i[1] ? entry_q[ridx2] : 6'd0;

  // ---------------------------------------------------------------------------
  // Frees: tag 0 is never returned to the list
  // ---------------------------------------------------------------------------
  assign fv1    = free_en_i[0] && (free_phydst1_i != 6'd0);
  assign fv2    = free_en_i[1] && (free_phydst2_i != 6'd0);
  assign free_n = popcnt2({fv2, fv1});

  assign widx1 = t_q[4:0];
  assign widx2 = t_q[4:0] + {4'b0000, fv1};

  // ---------------------------------------------------------------------------
  // Pointer advance
  // ---------------------------------------------------------------------------
  fl_ptr_adv u_hs_adv (
    .ptr_i (hs_q),
    .inc_i (hs_inc),
    .ptr_o (hs_adv)
  );

  fl_ptr_adv u_hc_adv (
    .ptr_i (hc_q),
    .inc_i (commit_cnt_i),
    .ptr_o (hc_d)
  );

  fl_ptr_adv u_t_adv (
    .ptr_i (t_q),
    .inc_i (free_n),
    .ptr_o (t_d)
  );

  // Flush rewinds to the committed head including this cycle's commits.
  assign hs_d = flush_i ? hc_d : hs_adv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q <= 6'd0;
      hc_q <= 6'd0;
      t_q  <= 6'b100000;
      for (int i = 0; i < int'(FL_DEPTH); i++) begin
        entry_q[i] <= phy_tag_t'(int'(ARCH_REGS) + i);
      end
    end else begin
      hs_q <= hs_d;
      hc_q <= hc_d;
      t_q  <= t_d;
      if (fv1) entry_q[widx1] <= free_phydst1_i;
      if (fv2) entry_q[widx2] <= free_phydst2_i;
    end
  end

`ifdef PHY_FREE_CHK_EN
  // ---------------------------------------------------------------------------
  // Consistency checks (sticky until reset)
  // ---------------------------------------------------------------------------
  fl_ptr_t    spec_dist;
  logic [6:0] cnt_after_free;
  logic       err_overfree, err_commit, err_dup, fl_err_q;

  assign cnt_after_free = {1'b0, free_cnt} + {5'b00000, free_n};
  assign err_overfree   = cnt_after_free > 7'd32;
  // Speculative allocations still ahead of the committed head.
  assign spec_dist      = hs_q - hc_q;
  assign err_commit     = spec_dist < {4'b0000, commit_cnt_i};
  assign err_dup        = fv1 && fv2 && (free_phydst1_i == free_phydst2_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fl_err_q <= 1'b0;
    end else if (err_overfree || err_commit || err_dup) begin
      fl_err_q <= 1'b1;
    end
  end

  assign fl_err_o = fl_err_q;
`endif

endmodule

// File: tb/tb_phy_free_list.sv
module tb_phy_free_list;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       stall_in;
  logic [1:0] alloc_req;
  logic [5:0] phydst1, phydst2;
  logic       stall_out;
  logic [1:0] commit_cnt;
  logic [1:0] free_en;
  logic [5:0] free_tag1, free_tag2;
  logic [5:0] free_count;
`ifdef PHY_FREE_CHK_EN
  logic       fl_err;
`endif

  int n_vec;
  int n_err;

  phy_free_list dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .stall_i         (stall_in),
    .alloc_req_i     (alloc_req),
    .alloc_phydst1_o (phydst1),
    .alloc_phydst2_o (phydst2),
    .stall_o         (stall_out),
    .commit_cnt_i    (commit_cnt),
    .free_en_i       (free_en),
    .free_phydst1_i  (free_tag1),
    .free_phydst2_i  (free_tag2),
`ifdef PHY_FREE_CHK_EN
    .fl_err_o        (fl_err),
`endif
    .free_count_o    (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    stall_in   = 1'b0;
    alloc_req  = 2'b00;
    commit_cnt = 2'd0;
    free_en    = 2'b00;
    free_tag1  = 6'd0;
    free_tag2  = 6'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    idle_inputs();
    #1;

    // Reset state
    do_reset();
    check_eq("rst_count", free_count, 32);
    check_eq("rst_stall", stall_out, 0);
    check_eq("rst_tag1", phydst1, 0);
    check_eq("rst_tag2", phydst2, 0);

    // Dual allocation, three cycles
    alloc_req = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("dual_tag1", phydst1, 32 + 2 * k);
      check_eq("dual_tag2", phydst2, 33 + 2 * k);
      tick();
    end
    check_eq("dual_count", free_count, 26);
    alloc_req = 2'b00;

    // Slot-2-only request
    do_reset();
    alloc_req = 2'b10;
    #1;
    check_eq("s2_tag1", phydst1, 0);
    check_eq("s2_tag2", phydst2, 32);
    tick();
    check_eq("s2_count", free_count, 31);
    alloc_req = 2'b01;
    #1;
    check_eq("s2_next", phydst1, 33);
    alloc_req = 2'b00;

    // Starve to one free tag, then stall
    do_reset();
    alloc_req = 2'b11;
    for (int k = 0; k < 15; k++) tick();
    alloc_req = 2'b01;
    tick();
    check_eq("starve_count", free_count, 1);
    alloc_req = 2'b11;
    #1;
    check_eq("starve_stall", stall_out, 1);
    check_eq("starve_cand1", phydst1, 63);
    check_eq("starve_cand2", phydst2, 32);
    tick();
    check_eq("starve_hold", free_count, 1);
    free_en   = 2'b01;
    free_tag1 = 6'd5;
    #1;
    check_eq("starve_nobypass", stall_out, 1);
    tick();
    free_en = 2'b00;
    free_tag1 = 6'd0;
    #1;
    check_eq("refill_count", free_count, 2);
    check_eq("refill_stall", stall_out, 0);
    check_eq("refill_tag2", phydst2, 5);
    alloc_req = 2'b00;

    // Downstream stall blocks allocation
    do_reset();
    alloc_req = 2'b11;
    stall_in  = 1'b1;
    tick();
    check_eq("stallin_count", free_count, 32);
    stall_in  = 1'b0;
    alloc_req = 2'b00;

    // Allocate 4 with one commit, then flush
    do_reset();
    alloc_req  = 2'b11;
    commit_cnt = 2'd1;
    tick();
    commit_cnt = 2'd0;
    tick();
    check_eq("pre_flush", free_count, 28);
    alloc_req = 2'b11;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    alloc_req = 2'b01;
    #1;
    check_eq("flush_count", free_count, 31);
    check_eq("flush_tag", phydst1, 33);
    tick();
    alloc_req = 2'b00;

    // Tag 0 free is dropped; only the nonzero tag advances T
    free_en   = 2'b11;
    free_tag1 = 6'd0;
    free_tag2 = 6'd7;
    tick();
    free_en   = 2'b00;
    free_tag2 = 6'd0;
    #1;
    check_eq("zero_drop", free_count, 31);

    // Drain, refill across the wrap, and reallocate in order
    do_reset();
    alloc_req = 2'b11;
    for (int k = 0; k < 16; k++) tick();
    check_eq("drain_count", free_count, 0);
    check_eq("drain_stall", stall_out, 1);
    alloc_req = 2'b00;
    free_en   = 2'b11;
    for (int k = 0; k < 16; k++) begin
      free_tag1 = 6'(1 + 2 * k);
      free_tag2 = 6'(2 + 2 * k);
      tick();
    end
    free_en   = 2'b00;
    free_tag1 = 6'd0;
    free_tag2 = 6'd0;
    #1;
    check_eq("wrap_count", free_count, 32);
    alloc_req = 2'b11;
    #1;
    for (int k = 0; k < 16; k++) begin
      check_eq("wrap_tag1", phydst1, 1 + 2 * k);
      check_eq("wrap_tag2", phydst2, 2 + 2 * k);
      tick();
    end
    check_eq("wrap_drain", free_count, 0);
    alloc_req = 2'b00;

    // Reset mid-operation
    do_reset();
    check_eq("rerst_count", free_count, 32);
    alloc_req = 2'b01;
    #1;
    check_eq("rerst_tag1", phydst1, 32);
    alloc_req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
